// File: rtl/tournament_selector_pkg.sv
// -----------------------------------------------------------------------------
// tournament_selector_pkg
//
// Shared types and constants for the tournament (meta) branch-predictor
// selector and its counter table.
//
//   lc3b_word          16-bit machine word (PC width)
//   lc3b_pred_sel      which direction predictor to trust (P0 local, P1 global)
//   tournament_state_t selector FSM: table-initialisation sweep, then normal run
//   meta_init_val()    weakly-P0 counter value for a given counter width
//   META_INIT_WEAK_P0  weakly-P0 value for the default 2-bit counters
// -----------------------------------------------------------------------------
package tournament_selector_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic {
        PRED_P0 = 1'b0,
        PRED_P1 = 1'b1
    } lc3b_pred_sel;

    typedef enum logic {
        TS_INIT = 1'b0,
        TS_RUN  = 1'b1
    } tournament_state_t;

    // Largest value whose MSB is still 0: the counter leans to P0 but a single
    // P1-favouring update flips the choice.
    function automatic int unsigned meta_init_val(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    localparam int unsigned META_DEFAULT_CTR_BITS = 2;
    localparam int unsigned META_INIT_WEAK_P0     = meta_init_val(META_DEFAULT_CTR_BITS);

endpackage

// File: rtl/meta_counter_table.sv
// -----------------------------------------------------------------------------
// meta_counter_table
//
// Storage for the tournament selector's saturating meta-counters. No reset:
// contents are defined by the selector's post-reset initialisation sweep.
//
// Ports:
//   clk_i        clock; the write port updates on the rising edge
//   rd_index_i   prediction-side read index (IF)
//   rd_data_o    counter at rd_index_i, combinational
//   rmw_index_i  update-side read index (WB read-modify-write)
//   rmw_data_o   counter at rmw_index_i, combinational
//   wr_en_i      write enable
//   wr_index_i   write index
//   wr_data_i    write data
//
// Reads return the pre-edge contents; a write is visible from the next cycle.
// -----------------------------------------------------------------------------
module meta_counter_table #(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned CTR_BITS   = 2
) (
    input  logic                  clk_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic [CTR_BITS-1:0]   rd_data_o,
    input  logic [INDEX_BITS-1:0] rmw_index_i,
    output logic [CTR_BITS-1:0]   rmw_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [CTR_BITS-1:0]   wr_data_i
);

    localparam int unsigned Depth = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_index_i];
    assign rmw_data_o = mem_q[rmw_index_i];

endmodule

// File: rtl/tournament_selector.sv
// -----------------------------------------------------------------------------
// tournament_selector
//
// Chooses between direction predictor P0 (local) and P1 (global) for the
// branch in IF using a table of saturating meta-counters. The table index is
// the PC (bit 0 dropped) XORed with a retired global history register; the
// pipeline carries that index to WB so the update hits the entry that was read.
// After reset a sweep writes the weakly-P0 value to every entry, one per cycle,
// and raises ready when the last entry has been written.
//
// Ports:
//   clk             clock, all state on rising edge
//   rst_n           synchronous active-low reset
//   if_pc           PC of the instruction in IF
//   if_index        table index used for this prediction
//   pred_select     0 = use P0, 1 = use P1 (forced 0 until ready)
//   ready           high once the initialisation sweep is complete
//   wb_isbranch     conditional branch retiring in WB this cycle
//   wb_index        if_index captured when that branch was in IF
//   wb_taken        resolved direction of the WB branch
//   p0_pred_correct P0 predicted the WB branch correctly
//   p1_pred_correct P1 predicted the WB branch correctly
// -----------------------------------------------------------------------------
module tournament_selector
    import tournament_selector_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned HIST_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  lc3b_word              if_pc,
    output logic [INDEX_BITS-1:0] if_index,
    output logic                  pred_select,
    output logic                  ready,
    input  logic                  wb_isbranch,
    input  logic [INDEX_BITS-1:0] wb_index,
    input  logic                  wb_taken,
    input  logic                  p0_pred_correct,
    input  logic                  p1_pred_correct
);

    // A zero-length history still needs a legal vector; it is simply not
    // folded into the index in that configuration.
    localparam int unsigned GhrW = (HIST_BITS > 0) ? HIST_BITS : 1;

    localparam logic [CTR_BITS-1:0] InitVal = CTR_BITS'(meta_init_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};

    if (HIST_BITS > INDEX_BITS) begin : g_bad_hist_bits
        $error("tournament_selector: HIST_BITS must not exceed INDEX_BITS");
    end
    if (CTR_BITS < 2 || CTR_BITS > 4) begin : g_bad_ctr_bits
        $error("tournament_selector: CTR_BITS must be in 2..4");
    end
    if (INDEX_BITS > 15) begin : g_bad_index_bits
        $error("tournament_selector: INDEX_BITS must fit in PC bits 15:1");
    end

    tournament_state_t     state_q,    state_d;
    logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [GhrW-1:0]       ghr_q,      ghr_d;
    logic                  ready_q,    ready_d;

    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_wr_index;
    logic [CTR_BITS-1:0]   tbl_wr_data;
    logic [CTR_BITS-1:0]   tbl_rd_data;
    logic [CTR_BITS-1:0]   tbl_rmw_data;

    logic [INDEX_BITS-1:0] pc_index;

    // -------------------------------------------------------------------------
    // Index hash
    // -------------------------------------------------------------------------
    assign pc_index = if_pc[INDEX_BITS:1];

    if (HIST_BITS > 0) begin : g_hist_index
        assign if_index = pc_index ^ INDEX_BITS'(ghr_q[HIST_BITS-1:0]);
    end else begin : g_pc_index
        assign if_index = pc_index;

        logic unused_ghr;
        assign unused_ghr = ^ghr_q;
    end

    // Bit 0 never distinguishes branches (word-aligned PCs); upper bits alias.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[15:INDEX_BITS+1], if_pc[0]};

    // -------------------------------------------------------------------------
    // Counter storage
    // -------------------------------------------------------------------------
    meta_counter_table #(
        .INDEX_BITS(INDEX_BITS),
        .CTR_BITS  (CTR_BITS)
    ) u_table (
        .clk_i      (clk),
        .rd_index_i (if_index),
        .rd_data_o  (tbl_rd_data),
        .rmw_index_i(wb_index),
        .rmw_data_o (tbl_rmw_data),
        .wr_en_i    (tbl_we),
        .wr_index_i (tbl_wr_index),
        .wr_data_i  (tbl_wr_data)
    );

    // -------------------------------------------------------------------------
    // Next-state: init sweep, saturating update, history shift
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        ghr_d        = ghr_q;
        ready_d      = ready_q;
        tbl_we       = 1'b0;
        tbl_wr_index = wb_index;
        tbl_wr_data  = tbl_rmw_data;

        unique case (state_q)
            TS_INIT: begin
                // WB traffic is ignored entirely while the sweep runs.
                tbl_we       = rst_n;
                tbl_wr_index = init_ptr_q;
                tbl_wr_data  = InitVal;
                init_ptr_d   = init_ptr_q + INDEX_BITS'(1);
                if (init_ptr_q == {INDEX_BITS{1'b1}}) begin
                    state_d = TS_RUN;
                    ready_d = 1'b1;
                end
            end

            TS_RUN: begin
                if (wb_isbranch) begin
                    // Retired history: shifts on every branch, counter or not.
                    ghr_d = GhrW'({ghr_q, wb_taken});
                    if (p1_pred_correct && !p0_pred_correct) begin
                        if (tbl_rmw_data != CtrMax) begin
                            tbl_we      = rst_n;
                            tbl_wr_data = tbl_rmw_data + CTR_BITS'(1);
                        end
                    end else if (p0_pred_correct && !p1_pred_correct) begin
                        if (tbl_rmw_data != '0) begin
                            tbl_we      = rst_n;
                            tbl_wr_data = tbl_rmw_data - CTR_BITS'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = TS_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= TS_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
            ready_q    <= ready_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    lc3b_pred_sel sel;

    always_comb begin
        sel = PRED_P0;
        if (ready_q && tbl_rd_data[CTR_BITS-1]) begin
            sel = PRED_P1;
        end
    end

    assign pred_select = sel;
    assign ready       = ready_q;

endmodule

// File: doc/tournament_selector.md
Name: tournament_selector

Overview:
- Parametrised successor to the 2-bit, 256-entry PC-indexed choice predictor.
- Holds a table of saturating meta-counters that picks between predictor P0 (local) and predictor P1 (global) for the branch in IF.
- Adds configurable depth and counter width, optional global-history (gshare-style) indexing, and a pipeline-carried index so the writeback update hits the same entry that was read.
- Adds a post-reset table-initialisation sweep with a ready flag.
- Sits beside both direction predictors in IF; updated from WB.

Parameters:
- INDEX_BITS, 8: table depth = 2**INDEX_BITS entries.
- CTR_BITS, 2: meta-counter width, legal range 2..4.
- HIST_BITS, 4: global history length; 0 = pure PC indexing; must be <= INDEX_BITS (elaboration-time assertion).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- if_pc  in  16  PC of instruction in IF (lc3b_word)
- if_index  out  INDEX_BITS  table index used for this prediction; pipeline carries it to WB
- pred_select  out  1  0 = use P0, 1 = use P1
- ready  out  1  high once init sweep is complete
- wb_isbranch  in  1  conditional branch retiring in WB this cycle
- wb_index  in  INDEX_BITS  if_index captured when that branch was in IF
- wb_taken  in  1  resolved direction of the WB branch
- p0_pred_correct  in  1  P0 predicted the WB branch correctly
- p1_pred_correct  in  1  P1 predicted the WB branch correctly

Behaviour:
- Index:
  - if_index = if_pc[INDEX_BITS:1] XOR zero-extended ghr[HIST_BITS-1:0].
  - When HIST_BITS = 0, if_index = if_pc[INDEX_BITS:1].
  - PC bit 0 is never used.
- Read:
  - Combinational from the table. pred_select = MSB of entry[if_index] when ready; forced 0 when not ready.
  - If the same entry is read and written in one cycle, the read returns the old value; the new value is visible the next cycle. No bypass.
- Update (only when ready && wb_isbranch), read-modify-write of entry[wb_index]:
  - p1 correct, p0 wrong: increment, saturating at 2**CTR_BITS-1.
  - p0 correct, p1 wrong: decrement, saturating at 0.
  - Both correct or both wrong: no write.
  - Write takes effect at the clock edge.
- GHR:
  - HIST_BITS-wide register, reset to 0.
  - When ready && wb_isbranch: ghr <= {ghr[HIST_BITS-2:0], wb_taken}.
  - This is the retired history; no speculative update and no repair.
  - GHR updates regardless of whether the counter changes.
- FSM states INIT and RUN:
  - rst_n = 0 at a clock edge: state <= INIT, init_ptr <= 0, ghr <= 0, ready <= 0.
  - INIT: each cycle write INIT_VAL = 2**(CTR_BITS-1)-1 (weakly-P0) to entry[init_ptr] and increment init_ptr. When init_ptr = 2**INDEX_BITS-1 is written, go to RUN and set ready <= 1.
  - Sweep takes exactly 2**INDEX_BITS cycles after the first clock edge with rst_n = 1.
  - RUN: normal operation. RUN never returns to INIT except via reset.
- Boundaries:
  - Reset mid-sweep or mid-run restarts the sweep from entry 0.
  - wb_isbranch during INIT is ignored: no counter write, no GHR shift.
  - init_ptr wraps cleanly at INDEX_BITS width; there is no separate terminal counter.
- Output reset values: pred_select 0, ready 0. if_index follows if_pc with ghr = 0.

Decomposition:
- lc3b_types package gains:
  - constant META_INIT_WEAK_P0
  - enum tournament_state_t {TS_INIT, TS_RUN}
  - typedef lc3b_pred_sel (1 bit: PRED_P0 = 0, PRED_P1 = 1)
- One sub-module, meta_counter_table:
  - parametrised INDEX_BITS/CTR_BITS storage
  - one async read port, one sync write port
  - second async read port for the WB read-modify-write
- tournament_selector owns the FSM, GHR, index hash and saturating-update logic.

Test Plan:
- Default params, rst_n low 2 cycles then high: ready stays 0 and pred_select stays 0 for exactly 256 cycles, then ready = 1. Backdoor check that every entry = 1.
- HIST_BITS=0, wb_index=0x12: two updates with p1 correct / p0 wrong take entry 1 -> 2 -> 3, and pred_select for if_pc=0x0024 reads 1. A third update holds at 3. Three p0-correct / p1-wrong updates give 2, 1, 0, and pred_select = 0. A fourth holds at 0.
- Both-correct and both-wrong updates on entry 0x12 (value 2): value stays 2. With HIST_BITS=4, ghr still shifts: after taken, not-taken, taken, ghr = 4'b0101.
- HIST_BITS=4, ghr=4'b0101, if_pc=0x0040: if_index = 0x20 ^ 0x05 = 0x25. Update with wb_index=0x25 modifies only entry 0x25; entries 0x20 and 0x24 are unchanged.
- Same-cycle read and write of entry 0x30 (value 1 -> 2): pred_select in that cycle is 0 (old MSB) and is 1 on the next cycle.
- rst_n pulsed low at sweep cycle 100 of a run where entry 0x05 = 3: sweep restarts, ready returns 256 cycles later, entry 0x05 = 1, ghr = 0. wb_isbranch pulses during the sweep leave no effect.
